// File: rtl/rf_pkg.sv
// Shared types and default sizes for the multi-port register file and its clear sequencer.
package rf_pkg;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_CLEAR,
    RF_DONE
  } rf_state_t;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 4;

endpackage

// File: rtl/rf_clear_fsm.sv
// Clear-sweep sequencer: walks idx over every register once per start pulse, driving a clear
// strobe and address, with busy/done status and the current state exported for observation.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              clear_en_o,
  output logic [ADDR_W-1:0] clear_addr_o,
  output rf_state_t         state_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  rf_state_t         state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q;
  logic              done_q;

  // Control handshake: start is a one-cycle request honoured only in IDLE; busy stays high for
  // exactly NUM_REGS cycles, then done pulses for one cycle. Requests outside IDLE are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RF_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RF_CLEAR: begin
          if (idx_q == LAST_IDX) begin
            state_q <= RF_DONE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        RF_DONE: begin
          state_q <= RF_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= RF_IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign clear_en_o   = (state_q == RF_CLEAR);
  assign clear_addr_o = idx_q;
  assign state_o      = state_q;

endmodule

// File: rtl/reg_file_multi.sv
// Parametrised register file with NUM_RD registered read ports, optional write-to-read bypass
// and a sequential clear sweep controlled by rf_clear_fsm.
module reg_file_multi
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     write_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     busy,
  output logic                     done
);

  localparam int              LIMIT_W   = ADDR_W + 1;
  localparam logic [ADDR_W:0] REG_LIMIT = LIMIT_W'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  rf_state_t         fsm_state;
  logic              clear_en;
  logic [ADDR_W-1:0] clear_addr;
  logic              wr_accept;

  rf_clear_fsm #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_clear_fsm (
    .clk         (clk),
    .rst         (reset),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .clear_en_o  (clear_en),
    .clear_addr_o(clear_addr),
    .state_o     (fsm_state)
  );

  // Only IDLE accepts writes, so the sweep's clear and a write never target the array together.
  assign wr_accept = write_en && (fsm_state == RF_IDLE) && ({1'b0, wr_addr} < REG_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (clear_en) begin
        regs_q[clear_addr] <= '0;
      end
      if (wr_accept) begin
        regs_q[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data_d = '0;
      if ({1'b0, addr} < REG_LIMIT) begin
        data_d = regs_q[addr];
      end
      if ((BYPASS != 0) && wr_accept && (addr == wr_addr)) begin
        data_d = wr_data;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_q;
  end

endmodule
